// File: rtl/timer_regs_ctrl.sv
// Down-counting timer peripheral behind the req/gnt register bus.
// Optional PRESCALE register at 0x10 when TIMER_PRESCALER_EN is defined.
package design_params_pkg;
    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 32;
endpackage

module timer_regs_ctrl
    import design_params_pkg::*;
#(
    parameter int P_ADDR_WIDTH  = ADDR_WIDTH,
    parameter int P_DATA_WIDTH  = DATA_WIDTH,
    parameter int P_GNT_LATENCY = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req,
    input  logic                    write_en,
    input  logic [P_ADDR_WIDTH-1:0] addr,
    input  logic [P_DATA_WIDTH-1:0] wdata,
    output logic                    gnt,
    output logic [P_DATA_WIDTH-1:0] rdata,
    output logic                    irq
);

    typedef enum logic [1:0] {IDLE, WAIT, GRANT} state_t;

    localparam logic [P_ADDR_WIDTH-1:0] A_CTRL   = P_ADDR_WIDTH'(8'h00);
    localparam logic [P_ADDR_WIDTH-1:0] A_LOAD   = P_ADDR_WIDTH'(8'h04);
    localparam logic [P_ADDR_WIDTH-1:0] A_COUNT  = P_ADDR_WIDTH'(8'h08);
    localparam logic [P_ADDR_WIDTH-1:0] A_STATUS = P_ADDR_WIDTH'(8'h0C);
    localparam logic [2:0] LAT_INIT = 3'(P_GNT_LATENCY - 1);

    state_t                  state;
    logic [2:0]              lat;
    logic [P_ADDR_WIDTH-1:0] addr_q;
    logic [P_DATA_WIDTH-1:0] wdata_q;
    logic                    we_q;

    logic [2:0]              ctrl;
    logic [P_DATA_WIDTH-1:0] load;
    logic [P_DATA_WIDTH-1:0] count;
    logic                    expired;
    logic                    tick;

    logic [2:0]              ctrl_n;
    logic [P_DATA_WIDTH-1:0] count_n;
    logic                    expired_n;
    logic                    exp_set;

    logic                    enter_grant;
    logic [P_ADDR_WIDTH-1:0] rd_addr;
    logic                    rd_we;
    logic [P_DATA_WIDTH-1:0] rd_val;

    logic wr;
    logic wr_ctrl;
    logic wr_load;
    logic wr_status;

    // With latency 1 the IDLE cycle goes straight to GRANT, so the read
    // mux must look at the live bus inputs rather than the latched copy.
    assign rd_addr = (state == IDLE) ? addr : addr_q;
    assign rd_we   = (state == IDLE) ? write_en : we_q;

    assign enter_grant = ((state == IDLE) && req && (LAT_INIT == 3'd0)) ||
                         ((state == WAIT) && (lat <= 3'd1));

    assign wr        = (state == GRANT) && we_q;
    assign wr_ctrl   = wr && (addr_q == A_CTRL);
    assign wr_load   = wr && (addr_q == A_LOAD);
    assign wr_status = wr && (addr_q == A_STATUS);

`ifdef TIMER_PRESCALER_EN
    localparam logic [P_ADDR_WIDTH-1:0] A_PRE = P_ADDR_WIDTH'(8'h10);

    logic [15:0] prescale;
    logic [15:0] pre_cnt;
    logic        wr_pre;

    assign wr_pre = wr && (addr_q == A_PRE);
    assign tick   = ctrl[0] && (pre_cnt == prescale);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescale <= '0;
            pre_cnt  <= '0;
        end else begin
            if (wr_pre)
                prescale <= wdata_q[15:0];
            if (!ctrl[0] || wr_ctrl || wr_pre || tick)
                pre_cnt <= '0;
            else
                pre_cnt <= pre_cnt + 16'd1;
        end
    end
`else
    assign tick = ctrl[0];
`endif

    always_comb begin
        rd_val = '0;
        case (rd_addr)
            A_CTRL:   rd_val[2:0] = ctrl;
            A_LOAD:   rd_val      = load;
            A_COUNT:  rd_val      = count;
            A_STATUS: rd_val[0]   = expired;
`ifdef TIMER_PRESCALER_EN
            A_PRE:    rd_val[15:0] = prescale;
`endif
            default:  rd_val      = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            lat     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            gnt     <= 1'b0;
            rdata   <= '0;
        end else begin
            gnt   <= enter_grant;
            rdata <= (enter_grant && !rd_we) ? rd_val : '0;
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        we_q    <= write_en;
                        lat     <= LAT_INIT;
                        state   <= (LAT_INIT == 3'd0) ? GRANT : WAIT;
                    end
                end
                WAIT: begin
                    lat <= lat - 3'd1;
                    if (lat <= 3'd1)
                        state <= GRANT;
                end
                GRANT:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Counter update first, bus write overrides; expiry beats W1C.
    always_comb begin
        ctrl_n  = ctrl;
        count_n = count;
        exp_set = 1'b0;
        if (tick) begin
            if (count != '0) begin
                count_n = count - 1'b1;
            end else begin
                exp_set = 1'b1;
                if (ctrl[1])
                    count_n = load;
                else
                    ctrl_n[0] = 1'b0;
            end
        end
        if (wr_ctrl)
            ctrl_n = wdata_q[2:0];
        if (wr_load)
            count_n = wdata_q;
        expired_n = exp_set | (expired & ~(wr_status & wdata_q[0]));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl    <= '0;
            load    <= '0;
            count   <= '0;
            expired <= 1'b0;
            irq     <= 1'b0;
        end else begin
            ctrl    <= ctrl_n;
            count   <= count_n;
            expired <= expired_n;
            if (wr_load)
                load <= wdata_q;
            irq <= expired & ctrl[2];
        end
    end

endmodule
